// File: rtl/dmem_ctrl.sv
// Data-side SRAM controller: posted store buffer drained by a SETUP/STROBE/HOLD
// write FSM, single-cycle loads registered into rdata at the MEM->WB edge.
module dmem_ctrl #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_we,
  input  logic              mem_oe,
  input  logic              mem_wb,
  output logic              mem_stall,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dout,
  output logic              sram_dout_en,
  input  logic [31:0]       sram_din,
  output logic [3:0]        sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  localparam int PW = $clog2(SB_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [ADDR_W-1:0] r_sb_addr [SB_DEPTH];
  logic [31:0]       r_sb_data [SB_DEPTH];
  logic [3:0]        r_sb_be_n [SB_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [PW:0]       r_count;
  logic [1:0]        r_state;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be_n;
  logic              w_hit, w_full, w_stall, w_push, w_pop, w_ld;
  logic [PW-1:0]     w_off;
  logic [7:0]        w_byte;

  assign w_waddr = mem_addr[ADDR_W+1:2];
  assign w_wdata = mem_wb ? {4{mem_wdata[7:0]}} : mem_wdata;
  assign w_be_n  = mem_wb ? ~(4'b0001 << mem_addr[1:0]) : 4'b0000;
  assign w_full  = (r_count == (PW+1)'(SB_DEPTH));

  // RAW check covers every live entry, including the head being written
  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_off = i[PW-1:0] - r_rptr;
      if (({1'b0, w_off} < r_count) && (r_sb_addr[i] == w_waddr)) w_hit = 1'b1;
    end
  end

  assign w_stall = !rst && ((mem_we && w_full) ||
                   (mem_oe && (w_hit || r_state == S_STROBE || r_state == S_HOLD)));
  assign mem_stall = w_stall;
  assign w_push = mem_we && !w_stall && !rst;
  assign w_ld   = mem_oe && !w_stall && !rst;
  assign w_pop  = (r_state == S_HOLD);
  assign w_byte = sram_din[8*mem_addr[1:0] +: 8];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sb_addr[r_wptr] <= w_waddr;
      r_sb_data[r_wptr] <= w_wdata;
      r_sb_be_n[r_wptr] <= w_be_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_ld) r_rdata <= mem_wb ? {{24{w_byte[7]}}, w_byte} : sram_din;
      case (r_state)
        S_IDLE:   if (r_count != '0) r_state <= S_SETUP;
        S_SETUP:  if (!w_ld) r_state <= S_STROBE;
        S_STROBE: r_state <= S_HOLD;
        default:  r_state <= (r_count > (PW+1)'(1)) ? S_SETUP : S_IDLE;
      endcase
    end
  end

  assign rdata = r_rdata;

  // An accepted load owns the bus; it can only coincide with IDLE or SETUP
  always_comb begin
    sram_addr    = '0;
    sram_dout    = '0;
    sram_dout_en = 1'b0;
    sram_be_n    = 4'hF;
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    if (!rst) begin
      if (w_ld) begin
        sram_addr = w_waddr;
        sram_be_n = 4'h0;
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end else if (r_state != S_IDLE) begin
        sram_addr    = r_sb_addr[r_rptr];
        sram_dout    = r_sb_data[r_rptr];
        sram_be_n    = r_sb_be_n[r_rptr];
        sram_dout_en = 1'b1;
        sram_ce_n    = 1'b0;
        sram_we_n    = (r_state != S_STROBE);
      end
    end
  end
endmodule
